inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Decoupling FIFO between the decoder and the execute (ALU) stage.
- Buffers decoded fat_instruction_t entries so that decode stalls and execute stalls do not propagate combinationally to each other.
- Valid/ready handshake on both sides, plus a flush input for redirect (e.g. after retq).
- Sits directly upstream of the ALU: its output entry is the instruction the execute stage consumes this cycle.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous discard of all entries
in_valid  input  1  decoder presents an instruction
in_inst  input  fat_instruction_t  decoded instruction from the decoder
in_ready  output  1  queue accepts in_inst this cycle
out_valid  output  1  head entry is valid for the execute stage
out_inst  output  fat_instruction_t  head entry
out_ready  input  1  execute stage consumes the head this cycle
count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH-entry array, wr_ptr and rd_ptr of $clog2(DEPTH) bits (wrap naturally), plus a count register.
- enq = in_valid && in_ready; deq = out_valid && out_ready.
- in_ready = (count != DEPTH). It is combinational from registered state only, never from out_ready. When full, no enqueue occurs even if a dequeue happens in the same cycle.
- out_valid = (count != 0); out_inst = mem[rd_ptr]. Both are combinational from registered state.
- On enq: mem[wr_ptr] <= in_inst; wr_ptr <= wr_ptr+1.
- On deq: rd_ptr <= rd_ptr+1.
- Count update: enq&&!deq -> count+1; deq&&!enq -> count-1; both or neither -> unchanged.
- Latency: an entry enqueued at edge N is visible on out_inst in cycle N+1.
- Ordering is strict FIFO; entries are never reordered or dropped except by flush or reset.
- Simultaneous enq and deq at count==1: the head is consumed, the new entry becomes the head next cycle, and count stays 1.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no special handling.
- Flush (sync):
  - Next edge sets wr_ptr=rd_ptr=0 and count=0.
  - Any enq or deq in the flush cycle is ignored; the ALU must not treat the flush-cycle head as consumed.
  - in_ready follows the normal rule during the flush cycle.
- Reset (sync, active-high):
  - wr_ptr=0, rd_ptr=0, count=0.
  - Outputs after reset: out_valid=0, in_ready=1, count=0.
  - out_inst is don't-care while out_valid=0; the bench must not check it.
  - Reset asserted mid-stream discards all contents, identical to flush.
  - Reset has priority over flush.
- Storage array is not reset.
- Instructions whose opcode_struct.name is 0 (empty decode) are queued like any other entry. Filtering them out is the ALU's job.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined: when count==0 and no flush, out_valid=in_valid and out_inst=in_inst (fall-through, zero latency).
  - If out_ready is also 1, the instruction is consumed without being written; pointers and count are unchanged.
  - If out_ready is 0, it is enqueued normally.
  - When bypass is active, out_valid and out_inst are combinational from in_valid and in_inst.
- Undefined: minimum latency is 1 cycle, as described above, and outputs depend on registered state only.

Decomposition:
- Shared package (alongside DecoderTypes), holding:
  - IQ_DEPTH_DEFAULT constant;
  - iq_count_t typedef;
  - fat_instruction_t itself stays in DecoderTypes and is imported.
- No sub-module: the storage array and pointer logic stay inline.

Test Plan:
- Reset then idle, out_ready=1: out_valid=0, in_ready=1, count=0 for 5 cycles.
- Enqueue 4 instructions (add, or, and, mov) with out_ready=0:
  - count reaches 4 and in_ready=0;
  - a 5th instruction (imul) held on in_valid is not accepted.
  - Then raise out_ready: dequeue order is add, or, and, mov, imul; count returns to 0.
- Continuous streaming, in_valid=out_ready=1 for 20 cycles with 20 distinct immediates:
  - all 20 emerge in order, 1 cycle after entry;
  - count stays at 1 once steady.
- Queue with 3 entries, assert flush for 1 cycle while in_valid=1 and out_ready=1:
  - next cycle count=0 and out_valid=0;
  - the flush-cycle input does not appear later.
- Fill to 2 entries, then assert reset while in_valid=1: next cycle count=0, out_valid=0, in_ready=1.
- With INST_QUEUE_BYPASS_EN defined, empty queue, in_valid=1, out_ready=1, movabs input:
  - out_inst equals movabs in the same cycle;
  - count stays 0.
  - Repeat with out_ready=0: count=1 next cycle.

Source files
------------

// File: rtl/decoder_types.sv
// Decoder output types shared between the decoder, the instruction queue and the ALU.
package DecoderTypes;

  typedef enum logic [3:0] {
    OPN_NONE   = 4'd0,
    OPN_ADD    = 4'd1,
    OPN_OR     = 4'd2,
    OPN_AND    = 4'd3,
    OPN_MOV    = 4'd4,
    OPN_IMUL   = 4'd5,
    OPN_MOVABS = 4'd6,
    OPN_RETQ   = 4'd7
  } opcode_name_t;

  typedef struct packed {
    opcode_name_t name;
    logic [1:0]   size;
  } opcode_struct_t;

  typedef struct packed {
    opcode_struct_t opcode_struct;
    logic [3:0]     reg_dst;
    logic [3:0]     reg_src;
    logic [63:0]    imm;
    logic [63:0]    pc;
  } fat_instruction_t;

endpackage

// File: rtl/inst_queue_pkg.sv
// Constants and types for the decode-to-execute instruction queue.
package inst_queue_pkg;

  localparam int IQ_DEPTH_DEFAULT = 4;
  localparam int IQ_CNT_W         = $clog2(IQ_DEPTH_DEFAULT) + 1;

  typedef logic [IQ_CNT_W-1:0] iq_count_t;

endpackage

// File: rtl/inst_queue.sv
// Decoupling FIFO between decode and execute with flush for redirects.
// Optional zero-latency fall-through when empty: define INST_QUEUE_BYPASS_EN.
module inst_queue
  import DecoderTypes::*;
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  fat_instruction_t in_inst,
  output logic             in_ready,
  output logic             out_valid,
  output fat_instruction_t out_inst,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fat_instruction_t mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, enq, deq, byp_take, wr_en, rd_adv;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != FULL_CNT);
  assign enq      = in_valid && in_ready;
  assign deq      = out_valid && out_ready;
  assign count    = count_q;

`ifdef INST_QUEUE_BYPASS_EN
  logic byp_active;
  assign byp_active = empty && !flush;
  assign out_valid  = byp_active ? in_valid : !empty;
  assign out_inst   = byp_active ? in_inst : mem_q[rd_ptr_q];
  // A fall-through instruction taken this cycle never touches storage.
  assign byp_take   = byp_active && in_valid && out_ready;
`else
  assign out_valid  = !empty;
  assign out_inst   = mem_q[rd_ptr_q];
  assign byp_take   = 1'b0;
`endif

  assign wr_en  = enq && !byp_take && !flush;
  assign rd_adv = deq && !byp_take && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_adv) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en && !rd_adv) begin
        count_d = count_q + 1'b1;
      end else if (rd_adv && !wr_en) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_inst;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a queue-based reference model feeds expected heads to a monitor.
`timescale 1ns/1ps
module tb_inst_queue;
  import DecoderTypes::*;
  import inst_queue_pkg::*;

  localparam int DEPTH = IQ_DEPTH_DEFAULT;
  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready;
  fat_instruction_t in_inst, out_inst;
  logic [CNT_W-1:0] count;

  int checks   = 0;
  int failures = 0;
  fat_instruction_t exp_q[$];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_inst  (in_inst),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_inst (out_inst),
    .out_ready(out_ready),
    .count    (count)
  );

  function automatic fat_instruction_t mk(input opcode_name_t n, input logic [63:0] imm);
    fat_instruction_t t;
    t.opcode_struct.name = n;
    t.opcode_struct.size = 2'($urandom_range(0, 3));
    t.reg_dst            = 4'($urandom_range(0, 15));
    t.reg_src            = 4'($urandom_range(0, 15));
    t.imm                = imm;
    t.pc                 = 64'h4000_0000 + imm * 4;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare status outputs with the model, update the model.
  task automatic step(input logic v, input fat_instruction_t inst, input logic rdy,
                      input logic fl, input logic rs, input bit chk_en, output bit acc);
    int sz;
    bit exp_ov;
    in_valid  = v;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
    reset     = rs;
    #1;
    sz     = exp_q.size();
    exp_ov = (sz != 0) || (BYP && !fl && v);
    if (chk_en) begin
      chk("count", 32'(count), 32'(sz));
      chk("in_ready", 32'(in_ready), 32'(sz != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
    end
    acc = v && (sz < DEPTH) && !fl && !rs;
    if (acc) exp_q.push_back(inst);
    @(posedge clk);
    if (fl || rs) exp_q.delete();
    #1;
  endtask

  initial begin : monitor
    fat_instruction_t exp;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0 && reset === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL deq_unexpected: got head %0h expected no entry at %0t", out_inst, $time);
        end else begin
          exp = exp_q.pop_front();
          if (out_inst !== exp) begin
            failures++;
            $display("FAIL deq_order: got %0h expected %0h at %0t", out_inst, exp, $time);
          end
        end
      end
    end
  end

  initial begin : driver
    bit a;
    fat_instruction_t nop, im;
    nop       = '0;
    in_valid  = 1'b0;
    in_inst   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;

    step(0, nop, 1, 0, 1, 0, a);
    repeat (5) step(0, nop, 1, 0, 0, 1, a);

    // fill to full, hold a fifth entry, then drain
    step(1, mk(OPN_ADD, 64'd1), 0, 0, 0, 1, a);
    step(1, mk(OPN_OR,  64'd2), 0, 0, 0, 1, a);
    step(1, mk(OPN_AND, 64'd3), 0, 0, 0, 1, a);
    step(1, mk(OPN_MOV, 64'd4), 0, 0, 0, 1, a);
    im = mk(OPN_IMUL, 64'd5);
    step(1, im, 0, 0, 0, 1, a);
    step(1, im, 0, 0, 0, 1, a);
    a = 1'b0;
    for (int i = 0; i < 8 && !a; i++) step(1, im, 1, 0, 0, 1, a);
    repeat (6) step(0, nop, 1, 0, 0, 1, a);

    // continuous streaming, including an empty-decode entry
    for (int i = 0; i < 20; i++)
      step(1, mk((i == 7) ? OPN_NONE : OPN_ADD, 64'(100 + i)), 1, 0, 0, 1, a);
    repeat (3) step(0, nop, 1, 0, 0, 1, a);

    // flush with 3 entries while both sides handshake
    for (int i = 0; i < 3; i++) step(1, mk(OPN_MOV, 64'(200 + i)), 0, 0, 0, 1, a);
    step(1, mk(OPN_RETQ, 64'd250), 1, 1, 0, 1, a);
    repeat (3) step(0, nop, 1, 0, 0, 1, a);

    // reset mid-stream with 2 entries
    for (int i = 0; i < 2; i++) step(1, mk(OPN_OR, 64'(300 + i)), 0, 0, 0, 1, a);
    step(1, mk(OPN_AND, 64'd310), 0, 0, 1, 1, a);
    repeat (3) step(0, nop, 1, 0, 0, 1, a);

    // empty queue with movabs, consumed immediately then held
    step(1, mk(OPN_MOVABS, 64'h1234_5678_9abc_def0), 1, 0, 0, 1, a);
    step(0, nop, 1, 0, 0, 1, a);
    step(1, mk(OPN_MOVABS, 64'h0fed_cba9_8765_4321), 0, 0, 0, 1, a);
    step(0, nop, 0, 0, 0, 1, a);
    repeat (3) step(0, nop, 1, 0, 0, 1, a);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0,
           mk(opcode_name_t'($urandom_range(0, 7)), {$urandom, $urandom}),
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 31) == 0,
           $urandom_range(0, 63) == 0, 1, a);
    end
    repeat (8) step(0, nop, 1, 0, 0, 1, a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
